seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, sequential successor to the 8-bit combinational ALU. Performs single-cycle arithmetic/logic ops and multi-cycle multiply, divide and modulo on WIDTH-bit operands. Uses a start/busy/done handshake and registers the result and flags. Sits between the register file and the writeback stage of the processor datapath.

## Interface
- WIDTH, 8, operand/result width in bits (≥4, power of two).
- ICLK  in  1  clock, rising edge.
- IRST  in  1  reset, asynchronous, active-high.
- IStart  in  1  start request; sampled only in IDLE.
- IRa  in  WIDTH  operand A.
- IRb  in  WIDTH  operand B.
- OPALU  in  4  opcode.
- OALUD  out  WIDTH  result register.
- OFgn  out  1  negative flag: OALUD MSB.
- OFgz  out  1  zero flag: OALUD == 0.
- OFgc  out  1  carry/borrow flag.
- OFgv  out  1  signed overflow or divide-by-zero flag.
- OBusy  out  1  multi-cycle operation in progress.
- ODone  out  1  one-cycle pulse; OALUD and flags updated this cycle.

## Operation
- Opcodes:
  - 0 PASSA, 1 ADD, 2 SUB (A−B), 3 AND, 4 OR, 5 XOR, 6 NOTA.
  - 7 SHL by 1, 8 SHR (logical) by 1.
  - 9 MUL: low WIDTH bits. 10 DIV: unsigned quotient. 11 MOD: unsigned remainder.
  - 12–15 reserved.
- Operands and opcode are captured on the IStart edge. Later input changes have no effect.
- States:
  - IDLE: IStart with opcode 0–8 or 12–15 → computes and stays in IDLE, ODone next cycle. IStart with opcode 9–11 → ITER, counter loaded with WIDTH−1.
  - ITER: one shift-add or restoring-divide step per cycle. At counter == 0 → FIN.
  - FIN: writes result and flags, pulses ODone → IDLE.
- Flags:
  - OFgc: ADD carry-out; SUB borrow (A<B unsigned); SHL/SHR bit shifted out; MUL high half ≠ 0; otherwise 0.
  - OFgv: ADD/SUB two's-complement overflow; DIV/MOD with B=0; otherwise 0.
- Divide by zero: DIV returns all-ones, MOD returns A. Latency is unchanged.
- Reserved opcodes: OALUD=0, OFgz=1, other flags 0, single-cycle.
- IStart while OBusy or in FIN is ignored. No queueing.
- OALUD and flags hold their last value until the next ODone.

## Timing
- Reset values: OALUD=0, all flags 0, OBusy=0, ODone=0, state IDLE, counter 0.
- IRST asserted mid-operation aborts immediately and returns all outputs to reset values. The partial result is discarded.
- Single-cycle op, IStart sampled at edge k: OALUD, flags and ODone valid after edge k+1. ODone lasts exactly one cycle.
- Multi-cycle op, IStart sampled at edge k:
  - OBusy high after edges k+1 … k+WIDTH (WIDTH cycles).
  - ODone high after edge k+WIDTH+1. OBusy is low in that cycle.
  - Total latency WIDTH+1 cycles.
- A new IStart is accepted in the ODone cycle (state is already IDLE after FIN). Back-to-back single-cycle ops give one result per cycle.
- ODone is never asserted without a preceding accepted IStart.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_PASSA … OP_MOD);
  - state encoding (ST_IDLE, ST_ITER, ST_FIN);
  - a helper classifying an opcode as multi-cycle.
- Sub-module alu_iter (parameter WIDTH) holds the iterative datapath:
  - accumulator, shifted operand, remainder registers;
  - counter;
  - shift-add step for MUL, restore step for DIV/MOD.
- Top level seq_alu holds the FSM, the single-cycle combinational unit, and the result/flag registers.

## Test plan
All scenarios use WIDTH=8.
- ADD A=200, B=100, start → next cycle OALUD=44, OFgc=1, OFgv=0, OFgn=0, ODone pulse of 1 cycle.
- SUB A=2, B=3 → OALUD=0xFF, OFgn=1, OFgc=1, OFgz=0. ADD A=100, B=100 → OALUD=200, OFgv=1.
- MUL A=20, B=15 → OBusy for 8 cycles, ODone at cycle 9, OALUD=44, OFgc=1. Changing IRa during OBusy does not alter the result.
- DIV A=100, B=7 → OALUD=14. MOD A=100, B=7 → OALUD=2. DIV A=5, B=0 → OALUD=0xFF, OFgv=1, latency 9 cycles.
- Start MUL, then assert IRST in busy cycle 3 → all outputs 0, no ODone. Start ADD 1+1 after release → OALUD=2 next cycle.
- IStart held high during a DIV → single ODone, no second op accepted until ODone. Opcode 14 → OALUD=0, OFgz=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification for seq_alu.
package alu_pkg;

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_NOTA  = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_MOD   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIN
  } state_t;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Start/busy/done handshake, operand and result/flag bundle between the register file side and seq_alu.
interface seq_alu_if #(parameter int WIDTH = 8) ();

  logic             IStart;
  logic [WIDTH-1:0] IRa;
  logic [WIDTH-1:0] IRb;
  logic [3:0]       OPALU;
  logic [WIDTH-1:0] OALUD;
  logic             OFgn;
  logic             OFgz;
  logic             OFgc;
  logic             OFgv;
  logic             OBusy;
  logic             ODone;

  modport master (
    output IStart, IRa, IRb, OPALU,
    input  OALUD, OFgn, OFgz, OFgc, OFgv, OBusy, ODone
  );

  modport slave (
    input  IStart, IRa, IRb, OPALU,
    output OALUD, OFgn, OFgz, OFgc, OFgv, OBusy, ODone
  );

endinterface

// File: rtl/alu_iter.sv
// Iterative datapath: shift-add multiplier and restoring divider run side by side, one step per cycle.
// Outputs are the register values after the current step, so the last step can be written directly.
module alu_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mlo;
  logic [WIDTH-1:0] rmd;
  logic [WIDTH-1:0] qsh;
  logic [WIDTH-1:0] opb;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   psum;
  logic [WIDTH:0]   rsh;

  always_comb begin
    psum    = {1'b0, acc} + (mlo[0] ? {1'b0, opb} : '0);
    prod_hi = psum[WIDTH:1];
    prod_lo = {psum[0], mlo[WIDTH-1:1]};
    // A zero divisor always subtracts: quotient fills with ones and A shifts into the remainder.
    rsh = {rmd, qsh[WIDTH-1]};
    if (rsh >= {1'b0, opb}) begin
      rem = rsh[WIDTH-1:0] - opb;
      quo = {qsh[WIDTH-2:0], 1'b1};
    end else begin
      rem = rsh[WIDTH-1:0];
      quo = {qsh[WIDTH-2:0], 1'b0};
    end
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      mlo <= '0;
      rmd <= '0;
      qsh <= '0;
      opb <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      mlo <= a;
      rmd <= '0;
      qsh <= a;
      opb <= b;
      cnt <= CW'(WIDTH - 1);
    end else if (step) begin
      acc <= prod_hi;
      mlo <= prod_lo;
      rmd <= rem;
      qsh <= quo;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete from IDLE, MUL/DIV/MOD iterate in alu_iter.
// Result and flags are registered and change only together with the ODone pulse.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic      ICLK,
  input logic      IRST,
  seq_alu_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic             bz_q;
  logic [WIDTH-1:0] res_q;
  logic             fn_q, fz_q, fc_q, fv_q;
  logic             done_q;

  logic             it_load, it_step, it_last;
  logic [WIDTH-1:0] it_lo, it_hi, it_quo, it_rem;

  logic             wr_en;
  logic [WIDTH-1:0] wr_res;
  logic             wr_c, wr_v;
  logic [WIDTH:0]   sum, dif;

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (ICLK),
    .rst     (IRST),
    .load    (it_load),
    .step    (it_step),
    .a       (bus.IRa),
    .b       (bus.IRb),
    .last    (it_last),
    .prod_lo (it_lo),
    .prod_hi (it_hi),
    .quo     (it_quo),
    .rem     (it_rem)
  );

  always_comb begin
    state_nx = state;
    it_load  = 1'b0;
    it_step  = 1'b0;
    wr_en    = 1'b0;
    wr_res   = '0;
    wr_c     = 1'b0;
    wr_v     = 1'b0;
    sum      = {1'b0, bus.IRa} + {1'b0, bus.IRb};
    dif      = {1'b0, bus.IRa} - {1'b0, bus.IRb};
    case (state)
      ST_IDLE: begin
        if (bus.IStart) begin
          if (is_multi(bus.OPALU)) begin
            it_load  = 1'b1;
            state_nx = ST_ITER;
          end else begin
            wr_en = 1'b1;
            case (bus.OPALU)
              OP_PASSA: wr_res = bus.IRa;
              OP_ADD: begin
                wr_res = sum[MSB:0];
                wr_c   = sum[WIDTH];
                wr_v   = (bus.IRa[MSB] == bus.IRb[MSB]) && (sum[MSB] != bus.IRa[MSB]);
              end
              OP_SUB: begin
                wr_res = dif[MSB:0];
                wr_c   = dif[WIDTH];
                wr_v   = (bus.IRa[MSB] != bus.IRb[MSB]) && (dif[MSB] != bus.IRa[MSB]);
              end
              OP_AND:  wr_res = bus.IRa & bus.IRb;
              OP_OR:   wr_res = bus.IRa | bus.IRb;
              OP_XOR:  wr_res = bus.IRa ^ bus.IRb;
              OP_NOTA: wr_res = ~bus.IRa;
              OP_SHL:  {wr_c, wr_res} = {bus.IRa, 1'b0};
              OP_SHR:  {wr_res, wr_c} = {1'b0, bus.IRa};
              default: wr_res = '0;
            endcase
          end
        end
      end
      ST_ITER: begin
        it_step = 1'b1;
        if (it_last) state_nx = ST_FIN;
      end
      ST_FIN: begin
        // FIN performs the final iteration step and commits its outcome in the same edge.
        it_step  = 1'b1;
        wr_en    = 1'b1;
        state_nx = ST_IDLE;
        case (op_q)
          OP_MUL: begin
            wr_res = it_lo;
            wr_c   = |it_hi;
          end
          OP_DIV: begin
            wr_res = it_quo;
            wr_v   = bz_q;
          end
          default: begin
            wr_res = it_rem;
            wr_v   = bz_q;
          end
        endcase
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge ICLK or posedge IRST) begin
    if (IRST) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      bz_q   <= 1'b0;
      res_q  <= '0;
      fn_q   <= 1'b0;
      fz_q   <= 1'b0;
      fc_q   <= 1'b0;
      fv_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= wr_en;
      if (it_load) begin
        op_q <= bus.OPALU;
        bz_q <= (bus.IRb == '0);
      end
      if (wr_en) begin
        res_q <= wr_res;
        fn_q  <= wr_res[MSB];
        fz_q  <= (wr_res == '0);
        fc_q  <= wr_c;
        fv_q  <= wr_v;
      end
    end
  end

  assign bus.OALUD = res_q;
  assign bus.OFgn  = fn_q;
  assign bus.OFgz  = fz_q;
  assign bus.OFgc  = fc_q;
  assign bus.OFgv  = fv_q;
  assign bus.OBusy = (state != ST_IDLE);
  assign bus.ODone = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): directed cases plus random ops against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         n, z, c, v;
    logic         multi;
    int unsigned  cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail = 0;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .ICLK (clk),
    .IRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ua, ub, sa, sb, r;
    int umax, smax, smin;
    umax = (1 << W) - 1;
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    e.c = 1'b0;
    e.v = 1'b0;
    e.multi = (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
    e.cyc = 0;
    r = 0;
    case (op)
      4'd0: r = ua;
      4'd1: begin r = ua + ub; e.c = (r > umax); e.v = (sa + sb > smax) || (sa + sb < smin); end
      4'd2: begin r = ua - ub; e.c = (ua < ub); e.v = (sa - sb > smax) || (sa - sb < smin); end
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua ^ ub;
      4'd6: r = umax - ua;
      4'd7: begin r = ua * 2; e.c = (ua > smax); end
      4'd8: begin r = ua / 2; e.c = (ua % 2 == 1); end
      4'd9: begin r = ua * ub; e.c = (r > umax); end
      4'd10: if (ub == 0) begin r = umax; e.v = 1'b1; end else r = ua / ub;
      4'd11: if (ub == 0) begin r = ua; e.v = 1'b1; end else r = ua % ub;
      default: r = 0;
    endcase
    e.res = r[W-1:0];
    e.n = e.res[W-1];
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic garbage();
    bus.OPALU = 4'($urandom);
    bus.IRa   = W'($urandom);
    bus.IRb   = W'($urandom);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      bus.IStart = 1'b0;
      garbage();
    end
  endtask

  // Called just after a negedge; returns at the negedge of the ODone cycle.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    exp_t e;
    int   n;
    e = model(op, a, b);
    n = e.multi ? W + 1 : 1;
    e.cyc = cyc + n;
    sbq.push_back(e);
    bus.IStart = 1'b1;
    bus.OPALU  = op;
    bus.IRa    = a;
    bus.IRb    = b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.IStart = hold && (i != n - 1);
      garbage();
    end
  endtask

  initial begin : monitor
    exp_t        e;
    int unsigned busy_run;
    busy_run = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) busy_run = 0;
      else if (bus.OBusy) busy_run++;
      if (bus.ODone) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_done: got ODone=1 at cycle %0d, expected no pending result", cyc);
        end else begin
          e = sbq.pop_front();
          chk("result", bus.OALUD, e.res);
          chk("flag_n", bus.OFgn, e.n);
          chk("flag_z", bus.OFgz, e.z);
          chk("flag_c", bus.OFgc, e.c);
          chk("flag_v", bus.OFgv, e.v);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_len", busy_run, e.multi ? W : 0);
          chk("busy_at_done", bus.OBusy, 0);
        end
        busy_run = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d results still pending", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.IStart = 1'b0;
    bus.OPALU  = '0;
    bus.IRa    = '0;
    bus.IRb    = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_result", bus.OALUD, 0);
    chk("reset_n", bus.OFgn, 0);
    chk("reset_z", bus.OFgz, 0);
    chk("reset_c", bus.OFgc, 0);
    chk("reset_v", bus.OFgv, 0);
    chk("reset_busy", bus.OBusy, 0);
    chk("reset_done", bus.ODone, 0);
    rst = 1'b0;
    idle(2);

    issue(4'd1, 8'd200, 8'd100, 1'b0);
    issue(4'd2, 8'd2, 8'd3, 1'b0);
    issue(4'd1, 8'd100, 8'd100, 1'b0);
    issue(4'd9, 8'd20, 8'd15, 1'b0);
    issue(4'd10, 8'd100, 8'd7, 1'b0);
    issue(4'd11, 8'd100, 8'd7, 1'b0);
    issue(4'd10, 8'd5, 8'd0, 1'b0);
    issue(4'd11, 8'd5, 8'd0, 1'b0);
    issue(4'd7, 8'h81, 8'd0, 1'b0);
    issue(4'd8, 8'h01, 8'd0, 1'b0);
    issue(4'd2, 8'h80, 8'd1, 1'b0);
    issue(4'd14, 8'd33, 8'd44, 1'b0);
    issue(4'd12, 8'd1, 8'd1, 1'b0);
    issue(4'd15, 8'hFF, 8'hFF, 1'b0);
    issue(4'd10, 8'd200, 8'd9, 1'b1);
    idle(3);

    // Abort a multiply in its third busy cycle.
    bus.IStart = 1'b1;
    bus.OPALU  = 4'd9;
    bus.IRa    = 8'd20;
    bus.IRb    = 8'd15;
    @(negedge clk);
    bus.IStart = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_abort", bus.OBusy, 1);
    rst = 1'b1;
    #1;
    chk("abort_result", bus.OALUD, 0);
    chk("abort_n", bus.OFgn, 0);
    chk("abort_z", bus.OFgz, 0);
    chk("abort_c", bus.OFgc, 0);
    chk("abort_v", bus.OFgv, 0);
    chk("abort_busy", bus.OBusy, 0);
    chk("abort_done", bus.ODone, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    issue(4'd1, 8'd1, 8'd1, 1'b0);

    for (int k = 0; k < 300; k++) begin
      idle($urandom_range(0, 2));
      issue(4'($urandom_range(0, 15)), W'($urandom),
            ($urandom_range(0, 5) == 0) ? 8'd0 : W'($urandom),
            ($urandom_range(0, 7) == 0));
    end

    idle(W + 4);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
